// File: rtl/matmul_seq_ctrl_if.sv
// Bus bundle between the matrix-multiply sequencer and its surroundings:
// UART receive strobe, operand memory write/read ports, UART transmit
// handshake and status flags.
//
// Handshake rules on this bus:
//   rx_valid is a one-cycle strobe; rx_data is only meaningful in that cycle.
//   wr_en is a one-cycle strobe; wr_sel/wr_addr/wr_data qualify it.
//   rd_data_a/rd_data_b follow rd_addr_a/rd_addr_b by exactly one cycle.
//   tx_start is a one-cycle strobe, issued only while tx_busy is low;
//   tx_busy rises the cycle after tx_start and falls when the byte is gone.
interface matmul_seq_ctrl_if #(
   parameter int AW = 4,
   parameter int DW = 8
);
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          wr_en;
   logic          wr_sel;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW-1:0] rd_addr_a;
   logic [AW-1:0] rd_addr_b;
   logic [DW-1:0] rd_data_a;
   logic [DW-1:0] rd_data_b;
   logic [7:0]    tx_data;
   logic          tx_start;
   logic          tx_busy;
   logic          busy;
   logic          done;
   logic          err;
   logic [2:0]    dbg_state;

   modport master (
      input  rx_data, rx_valid, rd_data_a, rd_data_b, tx_busy,
      output wr_en, wr_sel, wr_addr, wr_data, rd_addr_a, rd_addr_b,
             tx_data, tx_start, busy, done, err, dbg_state
   );

   modport slave (
      output rx_data, rx_valid, rd_data_a, rd_data_b, tx_busy,
      input  wr_en, wr_sel, wr_addr, wr_data, rd_addr_a, rd_addr_b,
             tx_data, tx_start, busy, done, err, dbg_state
   );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the UART matrix multiplier: loads N, then A and B row-major
// into the operand memories, computes every C[i][j] with a k-loop MAC and
// streams each RW-bit result to the UART transmitter MSB byte first.
module matmul_seq_ctrl #(
   parameter int MAX_N = 3,
   parameter int DW    = 8,
   parameter int AW    = 4,
   parameter int RW    = 24
) (
   input  logic              clk,
   input  logic              rst,
   matmul_seq_ctrl_if.master bus
);
   localparam int NB = RW / 8;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [2:0] {
      IDLE, LOAD_A, LOAD_B, CALC, SEND, SEND_WAIT, NEXT
   } state_t;

   state_t          state;
   logic [AW-1:0]   n;
   logic [AW-1:0]   idx;
   logic [AW-1:0]   i;
   logic [AW-1:0]   j;
   logic [AW-1:0]   cyc;
   logic [BW-1:0]   b;
   logic [RW-1:0]   acc;
   logic [RW-1:0]   result;
   logic            seen_busy;
   logic [AW-1:0]   last_idx;
   logic [2*DW-1:0] prod;

   logic            wr_en;
   logic            wr_sel;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic [AW-1:0]   rd_addr_a;
   logic [AW-1:0]   rd_addr_b;
   logic [7:0]      tx_data;
   logic            tx_start;
   logic            done;
   logic            err;

   assign last_idx = n * n - AW'(1);
   assign prod     = bus.rd_data_a * bus.rd_data_b;

   assign bus.wr_en     = wr_en;
   assign bus.wr_sel    = wr_sel;
   assign bus.wr_addr   = wr_addr;
   assign bus.wr_data   = wr_data;
   assign bus.rd_addr_a = rd_addr_a;
   assign bus.rd_addr_b = rd_addr_b;
   assign bus.tx_data   = tx_data;
   assign bus.tx_start  = tx_start;
   assign bus.done      = done;
   assign bus.err       = err;
   assign bus.busy      = (state != IDLE);
   assign bus.dbg_state = state;

   // Main sequencer: load operands, MAC each element, send it, advance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         n         <= '0;
         idx       <= '0;
         i         <= '0;
         j         <= '0;
         cyc       <= '0;
         b         <= '0;
         acc       <= '0;
         result    <= '0;
         seen_busy <= 1'b0;
         wr_en     <= 1'b0;
         wr_sel    <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         tx_data   <= '0;
         tx_start  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         wr_en    <= 1'b0;
         tx_start <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.rx_valid) begin
                  if (bus.rx_data != 8'd0 && bus.rx_data <= 8'(MAX_N)) begin
                     n     <= bus.rx_data[AW-1:0];
                     idx   <= '0;
                     state <= LOAD_A;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            LOAD_A, LOAD_B: begin
               if (bus.rx_valid) begin
                  wr_en   <= 1'b1;
                  wr_sel  <= (state == LOAD_B);
                  wr_addr <= idx;
                  wr_data <= bus.rx_data[DW-1:0];
                  if (idx == last_idx) begin
                     idx <= '0;
                     if (state == LOAD_A) begin
                        state <= LOAD_B;
                     end else begin
                        i     <= '0;
                        j     <= '0;
                        cyc   <= '0;
                        state <= CALC;
                     end
                  end else begin
                     idx <= idx + AW'(1);
                  end
               end
            end
            CALC: begin
               // cyc 0..N-1 issues addresses; products land two cycles later
               if (cyc == '0) acc <= '0;
               if (cyc < n) begin
                  rd_addr_a <= i * n + cyc;
                  rd_addr_b <= cyc * n + j;
               end
               if (cyc >= AW'(2)) begin
                  if (cyc == n + AW'(1)) begin
                     result <= acc + RW'(prod);
                     b      <= '0;
                     state  <= SEND;
                  end else begin
                     acc <= acc + RW'(prod);
                  end
               end
               cyc <= cyc + AW'(1);
            end
            SEND: begin
               if (!bus.tx_busy) begin
                  tx_start  <= 1'b1;
                  tx_data   <= result[RW-1 -: 8];
                  result    <= result << 8;
                  seen_busy <= 1'b0;
                  state     <= SEND_WAIT;
               end
            end
            SEND_WAIT: begin
               // byte is finished once busy has been seen high and then low
               if (bus.tx_busy) begin
                  seen_busy <= 1'b1;
               end else if (seen_busy) begin
                  if (b == BW'(NB - 1)) begin
                     state <= NEXT;
                  end else begin
                     b     <= b + BW'(1);
                     state <= SEND;
                  end
               end
            end
            NEXT: begin
               cyc <= '0;
               if (j == n - AW'(1)) begin
                  j <= '0;
                  if (i == n - AW'(1)) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     i     <= i + AW'(1);
                     state <= CALC;
                  end
               end else begin
                  j     <= j + AW'(1);
                  state <= CALC;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
Central sequencer for the UART matrix-multiplier top. It consumes received UART bytes (size N, then N*N bytes of A, then N*N bytes of B) and writes them into the A/B operand memories. It then walks every result element C[i][j] through a multiply-accumulate loop over k. Each 24-bit result is streamed to the UART transmitter as 3 bytes, MSB first.

Parameters:
MAX_N, 3, largest accepted matrix dimension
DW, 8, operand width (one UART byte)
AW, 4, operand memory address width (must satisfy 2^AW >= MAX_N*MAX_N)
RW, 24, accumulator/result width; always sent as RW/8 bytes

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rx_data  in  8  byte from UART receiver
rx_valid  in  1  one-cycle strobe, rx_data valid
wr_en  out  1  operand memory write strobe
wr_sel  out  1  0 = A memory, 1 = B memory
wr_addr  out  AW  row-major write index
wr_data  out  DW  write data
rd_addr_a  out  AW  A read address
rd_addr_b  out  AW  B read address
rd_data_a  in  DW  A read data, synchronous, 1-cycle latency
rd_data_b  in  DW  B read data, synchronous, 1-cycle latency
tx_data  out  8  byte to UART transmitter
tx_start  out  1  one-cycle send strobe
tx_busy  in  1  transmitter busy; rises the cycle after tx_start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last byte of C completes
err  out  1  one-cycle pulse on an invalid size byte

Behaviour:
- Reset (rst=0, async): state IDLE; all counters, accumulator and N cleared; every output 0.
- States: IDLE, LOAD_A, LOAD_B, CALC, SEND, SEND_WAIT, NEXT.
- IDLE:
  - rx_valid with 1 <= rx_data <= MAX_N: latch N, clear idx, go to LOAD_A.
  - rx_valid with rx_data = 0 or rx_data > MAX_N: err pulse next cycle, stay IDLE.
- LOAD_A / LOAD_B:
  - Each rx_valid gives, on the next cycle, a single-cycle wr_en with wr_sel, wr_addr = idx, wr_data = byte; idx increments.
  - When idx reaches N*N-1 on a write: idx clears; LOAD_A goes to LOAD_B, LOAD_B goes to CALC with i = j = 0.
- CALC, per element:
  - Cycle 0 clears acc.
  - For k = 0..N-1, one per cycle: rd_addr_a = i*N+k, rd_addr_b = k*N+j.
  - Each product rd_data_a*rd_data_b (unsigned, 16 bits) is added into acc the cycle after its address.
  - After the last add, acc is latched into result and the FSM goes to SEND with byte counter b = 0.
  - Element latency: N+2 cycles from CALC entry to SEND.
  - acc is RW bits; the maximum 3*255*255 = 0x02FA03 cannot overflow at the default parameters.
- SEND:
  - When tx_busy = 0, pulse tx_start with tx_data = result[RW-1-8b -: 8], then go to SEND_WAIT.
  - tx_start is never asserted while tx_busy = 1.
- SEND_WAIT: wait for tx_busy to rise, then fall.
  - If b < RW/8-1: b++, back to SEND.
  - Otherwise go to NEXT.
- NEXT:
  - Advance j; on wrap, j = 0 and i++.
  - If i == N-1 and j == N-1 were just completed: done pulse, go to IDLE.
  - Otherwise go to CALC.
- rx_valid in CALC/SEND/SEND_WAIT/NEXT: byte discarded; no memory write; state unaffected.
- rx_valid and the final transition to IDLE in the same cycle: byte discarded. IDLE samples only from the following cycle.
- rst asserted mid-operation in any state: immediate return to IDLE. Memory contents are not cleared; the next transfer overwrites them.
- Read addresses must be stable the cycle before data is used. No write may occur outside LOAD_A/LOAD_B.

Test Plan:
1. Size 02, A = 01 02 03 04, B = 05 06 07 08 -> 8 wr_en pulses (A addr 0-3, then B addr 0-3). tx bytes 00 00 13, 00 00 16, 00 00 2B, 00 00 32, then a single done pulse.
2. Size 03, all 18 operand bytes FF -> nine results 0x02FA03, i.e. 27 tx bytes repeating 02 FA 03; busy stays high until done.
3. Size 00, then size 04 -> err pulses twice; no wr_en; state stays IDLE. Then size 01, A = 07, B = 09 -> tx 00 00 3F, done.
4. tx_busy held high for 50 cycles after each tx_start -> exactly one tx_start per byte, never while tx_busy = 1; byte order unchanged.
5. Extra rx bytes (AA, BB) injected during SEND of test 1 -> no wr_en; results identical to test 1.
6. Assert rst after two B bytes of test 1 -> all outputs 0 immediately. Rerun test 1 from the size byte -> identical output.
